// File: rtl/hram_avalon_arbiter.sv
// Round-robin two-port Avalon-MM arbiter in front of the HyperRAM controller; read responses are steered by a tag FIFO.
// Latency: one-cycle grant bubble from idle, none on hold-expiry switch, zero-latency response path; stalls come from ctrl_waitrequest or a full tag FIFO.
module hram_avalon_arbiter #(
   parameter int HOLD_MAX    = 4,
   parameter int MAX_PENDING = 4,
   parameter int ADDR_W      = 22
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [15:0]       m0_writedata,
   input  logic [1:0]        m0_byteenable,
   output logic              m0_waitrequest,
   output logic [15:0]       m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [15:0]       m1_writedata,
   input  logic [1:0]        m1_byteenable,
   output logic              m1_waitrequest,
   output logic [15:0]       m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] ctrl_address,
   output logic              ctrl_read,
   output logic              ctrl_write,
   output logic [15:0]       ctrl_writedata,
   output logic [1:0]        ctrl_byteenable,
   input  logic              ctrl_waitrequest,
   input  logic [15:0]       ctrl_readdata,
   input  logic              ctrl_readdatavalid,
   output logic              error
);
   localparam int PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
   localparam int CW = $clog2(MAX_PENDING + 1);
   localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_M0, ST_M1} state_t;

   state_t           state, state_nxt;
   logic             last_id, last_nxt;
   logic [HW-1:0]    hold_cnt, hold_nxt;
   logic [PW-1:0]    rd_ptr, wr_ptr;
   logic [CW-1:0]    occ;
   logic [MAX_PENDING-1:0] tag_mem;

   logic grant_valid, grant_id;
   logic req0, req1, req_g, req_o;
   logic g_read, g_write;
   logic fifo_full, fifo_empty, rd_block;
   logic accept, push, pop, head;
   state_t other_st;

   assign req0        = m0_read | m0_write;
   assign req1        = m1_read | m1_write;
   assign grant_valid = (state != ST_IDLE);
   assign grant_id    = (state == ST_M1);

   assign g_read  = grant_id ? m1_read  : m0_read;
   assign g_write = grant_id ? m1_write : m0_write;

   assign fifo_full  = (occ == CW'(MAX_PENDING));
   assign fifo_empty = (occ == '0);
   assign pop        = ctrl_readdatavalid & ~fifo_empty;
   // A pop in the same cycle frees the slot, so a full FIFO only blocks when no response arrives.
   assign rd_block   = fifo_full & ~ctrl_readdatavalid;

   assign ctrl_read       = grant_valid & g_read & ~rd_block;
   assign ctrl_write      = grant_valid & g_write & ~g_read;
   assign ctrl_address    = grant_id ? m1_address    : m0_address;
   assign ctrl_writedata  = grant_id ? m1_writedata  : m0_writedata;
   assign ctrl_byteenable = grant_id ? m1_byteenable : m0_byteenable;

   assign m0_waitrequest = (state != ST_M0) | ctrl_waitrequest | (m0_read & rd_block);
   assign m1_waitrequest = (state != ST_M1) | ctrl_waitrequest | (m1_read & rd_block);

   assign accept = (ctrl_read | ctrl_write) & ~ctrl_waitrequest;
   assign push   = accept & ctrl_read;

   assign head             = tag_mem[rd_ptr];
   assign m0_readdata      = ctrl_readdata;
   assign m1_readdata      = ctrl_readdata;
   assign m0_readdatavalid = pop & ~head;
   assign m1_readdatavalid = pop & head;

   assign req_g    = grant_id ? req1 : req0;
   assign req_o    = grant_id ? req0 : req1;
   assign other_st = grant_id ? ST_M0 : ST_M1;

   always_comb begin
      state_nxt = state;
      last_nxt  = last_id;
      hold_nxt  = hold_cnt;
      if (state == ST_IDLE) begin
         hold_nxt = '0;
         if (req0 && (!req1 || last_id))
            state_nxt = ST_M0;
         else if (req1)
            state_nxt = ST_M1;
      end else if (!req_g) begin
         hold_nxt  = '0;
         last_nxt  = grant_id;
         state_nxt = req_o ? other_st : ST_IDLE;
      end else if (accept) begin
         if (hold_cnt == HW'(HOLD_MAX - 1)) begin
            hold_nxt = '0;
            if (req_o) begin
               state_nxt = other_st;
               last_nxt  = grant_id;
            end
         end else begin
            hold_nxt = hold_cnt + HW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         last_id  <= 1'b1;
         hold_cnt <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         occ      <= '0;
         error    <= 1'b0;
      end else begin
         state    <= state_nxt;
         last_id  <= last_nxt;
         hold_cnt <= hold_nxt;
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            occ <= occ + CW'(1);
         else if (pop && !push)
            occ <= occ - CW'(1);
         if (ctrl_readdatavalid && fifo_empty)
            error <= 1'b1;
      end
   end

   // Tag storage needs no reset: entries are only read behind the occupancy count.
   always_ff @(posedge clock) begin
      if (push)
         tag_mem[wr_ptr] <= grant_id;
   end
endmodule

// File: tb/tb_hram_avalon_arbiter.sv
// Directed bench for hram_avalon_arbiter: arbitration, hold expiry, read steering, FIFO-full stall, error flag, reset.
module tb_hram_avalon_arbiter;
   logic        clock = 1'b0;
   logic        reset;
   logic [21:0] m0_address, m1_address, ctrl_address;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [15:0] m0_writedata, m1_writedata, ctrl_writedata;
   logic [1:0]  m0_byteenable, m1_byteenable, ctrl_byteenable;
   logic        m0_waitrequest, m1_waitrequest;
   logic [15:0] m0_readdata, m1_readdata, ctrl_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic        ctrl_read, ctrl_write, ctrl_waitrequest, ctrl_readdatavalid;
   logic        error;

   int n_checks = 0;
   int n_fail   = 0;

   hram_avalon_arbiter #(.HOLD_MAX(4), .MAX_PENDING(4), .ADDR_W(22)) dut (
      .clock(clock), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .ctrl_address(ctrl_address), .ctrl_read(ctrl_read), .ctrl_write(ctrl_write),
      .ctrl_writedata(ctrl_writedata), .ctrl_byteenable(ctrl_byteenable),
      .ctrl_waitrequest(ctrl_waitrequest), .ctrl_readdata(ctrl_readdata),
      .ctrl_readdatavalid(ctrl_readdatavalid), .error(error)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [15:0] rsp1 [3];
   logic [15:0] rsp3 [3];
   logic        exp0 [3];

   initial begin
      rsp1 = '{16'hA0A0, 16'hA1A1, 16'hA2A2};
      rsp3 = '{16'h1111, 16'h2222, 16'h3333};
      exp0 = '{1'b1, 1'b0, 1'b1};
      reset = 1'b1;
      m0_address = '0; m1_address = '0;
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
      m0_writedata = '0; m1_writedata = '0;
      m0_byteenable = 2'b11; m1_byteenable = 2'b11;
      ctrl_waitrequest = 0; ctrl_readdata = '0; ctrl_readdatavalid = 0;

      // Reset state
      tick(); tick();
      chk("rst_m0_wait", 32'(m0_waitrequest), 1);
      chk("rst_m1_wait", 32'(m1_waitrequest), 1);
      chk("rst_ctrl_read", 32'(ctrl_read), 0);
      chk("rst_ctrl_write", 32'(ctrl_write), 0);
      chk("rst_error", 32'(error), 0);
      chk("rst_m0_rdv", 32'(m0_readdatavalid), 0);
      reset = 1'b0;

      // Single port: three reads, one controller stall cycle
      m0_read = 1; m0_address = 22'h10;
      #1 chk("t1_bubble_wait", 32'(m0_waitrequest), 1);
      tick();
      ctrl_waitrequest = 1;
      #1 chk("t1_stall_wait", 32'(m0_waitrequest), 1);
      chk("t1_stall_read", 32'(ctrl_read), 1);
      tick();
      ctrl_waitrequest = 0;
      #1 chk("t1_addr0", 32'(ctrl_address), 32'h10);
      chk("t1_wait0", 32'(m0_waitrequest), 0);
      tick(); m0_address = 22'h11;
      #1 chk("t1_addr1", 32'(ctrl_address), 32'h11);
      tick(); m0_address = 22'h12;
      #1 chk("t1_addr2", 32'(ctrl_address), 32'h12);
      tick(); m0_read = 0;
      for (int i = 0; i < 3; i++) begin
         ctrl_readdatavalid = 1; ctrl_readdata = rsp1[i];
         #1 chk("t1_m0_rdv", 32'(m0_readdatavalid), 1);
         chk("t1_m0_data", 32'(m0_readdata), 32'(rsp1[i]));
         chk("t1_m1_rdv", 32'(m1_readdatavalid), 0);
         tick();
      end
      ctrl_readdatavalid = 0;
      #1 chk("t1_error", 32'(error), 0);

      // Tie after reset: 4 m0 writes then 4 m1 writes, alternating without bubbles
      reset = 1; tick(); reset = 0;
      m0_write = 1; m1_write = 1; m0_writedata = 16'h0A00; m1_writedata = 16'h0B00;
      tick();
      for (int i = 0; i < 16; i++) begin
         chk("t2_write", 32'(ctrl_write), 1);
         chk("t2_wdata", 32'(ctrl_writedata), ((i >> 2) & 1) != 0 ? 32'h0B00 : 32'h0A00);
         tick();
      end
      m0_write = 0; m1_write = 0;
      tick(); tick();

      // Interleaved read routing m0, m1, m0
      reset = 1; tick(); reset = 0;
      m0_read = 1; m0_address = 22'h20; m1_read = 1; m1_address = 22'h30;
      tick();
      chk("t3_addr_a", 32'(ctrl_address), 32'h20);
      chk("t3_read_a", 32'(ctrl_read), 1);
      chk("t3_m1_wait", 32'(m1_waitrequest), 1);
      tick(); m0_read = 0;
      tick();
      chk("t3_addr_b", 32'(ctrl_address), 32'h30);
      chk("t3_read_b", 32'(ctrl_read), 1);
      m0_read = 1; m0_address = 22'h21;
      #1 chk("t3_m0_wait", 32'(m0_waitrequest), 1);
      tick(); m1_read = 0;
      tick();
      chk("t3_addr_c", 32'(ctrl_address), 32'h21);
      chk("t3_m0_go", 32'(m0_waitrequest), 0);
      tick(); m0_read = 0;
      repeat (6) tick();
      for (int i = 0; i < 3; i++) begin
         ctrl_readdatavalid = 1; ctrl_readdata = rsp3[i];
         #1 chk("t3_m0_rdv", 32'(m0_readdatavalid), 32'(exp0[i]));
         chk("t3_m1_rdv", 32'(m1_readdatavalid), 32'(!exp0[i]));
         chk("t3_data", 32'(m1_readdata), 32'(rsp3[i]));
         tick();
      end
      ctrl_readdatavalid = 0;

      // FIFO full: 4 reads, switch to m1 write, stall, release on pop
      reset = 1; tick(); reset = 0;
      m0_read = 1; m0_address = 22'h40;
      m1_write = 1; m1_address = 22'h50; m1_writedata = 16'hBEEF;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("t4_read", 32'(ctrl_read), 1);
         tick();
      end
      chk("t4_m1_write", 32'(ctrl_write), 1);
      chk("t4_m1_wdata", 32'(ctrl_writedata), 32'hBEEF);
      chk("t4_m1_addr", 32'(ctrl_address), 32'h50);
      chk("t4_m0_wait", 32'(m0_waitrequest), 1);
      tick(); m1_write = 0;
      #1 chk("t4_bubble", 32'(ctrl_write), 0);
      tick();
      chk("t4_full_wait", 32'(m0_waitrequest), 1);
      chk("t4_full_read", 32'(ctrl_read), 0);
      ctrl_readdatavalid = 1; ctrl_readdata = 16'h5555;
      #1 chk("t4_pop_read", 32'(ctrl_read), 1);
      chk("t4_pop_wait", 32'(m0_waitrequest), 0);
      chk("t4_pop_rdv", 32'(m0_readdatavalid), 1);
      tick(); ctrl_readdatavalid = 0;
      #1 chk("t4_full_again", 32'(m0_waitrequest), 1);
      m0_read = 0;

      // Spurious response
      reset = 1; tick(); reset = 0;
      ctrl_readdatavalid = 1; ctrl_readdata = 16'hDEAD;
      #1 chk("t5_m0_rdv", 32'(m0_readdatavalid), 0);
      chk("t5_m1_rdv", 32'(m1_readdatavalid), 0);
      chk("t5_err_pre", 32'(error), 0);
      tick(); ctrl_readdatavalid = 0;
      #1 chk("t5_err_set", 32'(error), 1);
      repeat (3) tick();
      chk("t5_err_held", 32'(error), 1);

      // Reset mid-burst with m1 granted and reads outstanding
      m1_read = 1; m1_address = 22'h60;
      tick(); tick(); tick();
      chk("t6_m1_granted", 32'(m1_waitrequest), 0);
      reset = 1; m0_write = 1; m0_writedata = 16'h0C0C;
      tick();
      chk("t6_m0_wait", 32'(m0_waitrequest), 1);
      chk("t6_m1_wait", 32'(m1_waitrequest), 1);
      chk("t6_read", 32'(ctrl_read), 0);
      chk("t6_write", 32'(ctrl_write), 0);
      chk("t6_error", 32'(error), 0);
      reset = 0;
      tick();
      chk("t6_tie_write", 32'(ctrl_write), 1);
      chk("t6_tie_wdata", 32'(ctrl_writedata), 32'h0C0C);
      chk("t6_tie_m1_wait", 32'(m1_waitrequest), 1);
      ctrl_readdatavalid = 1;
      #1 chk("t6_empty_m1_rdv", 32'(m1_readdatavalid), 0);
      chk("t6_empty_m0_rdv", 32'(m0_readdatavalid), 0);
      tick(); ctrl_readdatavalid = 0;
      #1 chk("t6_empty_err", 32'(error), 1);
      m0_write = 0; m1_read = 0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
